// File: rtl/mux_pipe_reg.sv
// ---------------------------------------------------------------------------
// mux_pipe_reg
//   N-way multiplexer followed by a single output register, used for operand,
//   forwarding and writeback selection in the pipelined MIPS core. Besides the
//   plain select it tracks a valid bit, honours stall (hold) and flush (bubble),
//   and flags out-of-range selects with a sticky-per-capture error bit and a
//   saturating 8-bit error counter.
//
// Parameters
//   WIDTH      data width of every input and of the output
//   NUM_IN     number of selectable inputs (2..16)
//   SEL_W      select width, 2**SEL_W >= NUM_IN
//   RESET_VAL  value driven on out_data after reset, flush or a bad select
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_bus     packed inputs, input k = in_bus[k*WIDTH +: WIDTH]
//   sel        binary select
//   in_valid   inputs and select are meaningful this cycle
//   stall      hold every output register
//   flush      load a bubble (RESET_VAL, invalid, no error)
//   out_data   registered selected input
//   out_valid  out_data holds a valid result
//   sel_err    last captured valid select was >= NUM_IN
//   err_count  saturating count of out-of-range valid selects
// ---------------------------------------------------------------------------
module mux_pipe_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          NUM_IN    = 4,
  parameter int unsigned          SEL_W     = 2,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [7:0]              err_count
);

  // Reject configurations the select cannot address or that are not a mux.
  generate
    if ((NUM_IN < 2) || ((2 ** SEL_W) < NUM_IN)) begin : g_paramCheck
      $error("mux_pipe_reg: NUM_IN must be >= 2 and 2**SEL_W >= NUM_IN");
    end
  endgenerate

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_selErr;
  logic [7:0]       r_errCount;

  logic [WIDTH-1:0] w_selected;
  logic             w_selInRange;
  int unsigned      w_selIdx;

  // Select codes at or above NUM_IN (possible when NUM_IN is not a power of
  // two) are treated as errors rather than aliasing onto a real input.
  always_comb begin
    w_selIdx     = 32'(sel);
    w_selInRange = (w_selIdx < NUM_IN);
  end

  // Compare-and-pick mux so no part-select ever reaches past in_bus, even for
  // the unused select codes.
  always_comb begin
    w_selected = RESET_VAL;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (w_selIdx == k) begin
        w_selected = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: flush beats stall, stall freezes everything (including the
  // error counter), an idle cycle only drops the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= RESET_VAL;
      r_valid    <= 1'b0;
      r_selErr   <= 1'b0;
      r_errCount <= 8'd0;
    end else if (flush) begin
      r_data     <= RESET_VAL;
      r_valid    <= 1'b0;
      r_selErr   <= 1'b0;
    end else if (stall) begin
      r_data     <= r_data;
      r_valid    <= r_valid;
      r_selErr   <= r_selErr;
    end else if (!in_valid) begin
      r_valid    <= 1'b0;
    end else if (w_selInRange) begin
      r_data     <= w_selected;
      r_valid    <= 1'b1;
      r_selErr   <= 1'b0;
    end else begin
      r_data     <= RESET_VAL;
      r_valid    <= 1'b1;
      r_selErr   <= 1'b1;
      if (r_errCount != 8'hFF) begin
        r_errCount <= r_errCount + 8'd1;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign sel_err   = r_selErr;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_pipe_reg
//   Drives a 4-input and a 3-input instance of mux_pipe_reg with the same
//   stimulus. At every rising edge the expected register contents of each
//   instance are computed from the behavioural rules and queued; a monitor on
//   the falling edge pops and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_mux_pipe_reg;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [4*W-1:0] inBus;
  logic [1:0]     sel;
  logic           inValid;
  logic           stall;
  logic           flush;

  logic [W-1:0]   outData4, outData3;
  logic           outValid4, outValid3;
  logic           selErr4, selErr3;
  logic [7:0]     errCount4, errCount3;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         valid;
    logic         err;
    int           cnt;
  } expState_t;

  expState_t model4, model3;
  expState_t q4[$];
  expState_t q3[$];

  mux_pipe_reg #(.WIDTH(W), .NUM_IN(4), .SEL_W(2), .RESET_VAL('0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_bus(inBus), .sel(sel),
    .in_valid(inValid), .stall(stall), .flush(flush),
    .out_data(outData4), .out_valid(outValid4), .sel_err(selErr4),
    .err_count(errCount4)
  );

  mux_pipe_reg #(.WIDTH(W), .NUM_IN(3), .SEL_W(2), .RESET_VAL('0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(inBus[3*W-1:0]), .sel(sel),
    .in_valid(inValid), .stall(stall), .flush(flush),
    .out_data(outData3), .out_valid(outValid3), .sel_err(selErr3),
    .err_count(errCount3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running (actual timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic expState_t resetState();
    expState_t s;
    s.data = '0; s.valid = 1'b0; s.err = 1'b0; s.cnt = 0;
    return s;
  endfunction

  // Behavioural rules for one clock edge of an instance with numIn inputs.
  function automatic expState_t nextState(expState_t s, int numIn);
    expState_t n = s;
    int idx = int'(sel);
    if (flush) begin
      n.data = '0; n.valid = 1'b0; n.err = 1'b0;
    end else if (stall) begin
      n = s;
    end else if (!inValid) begin
      n.valid = 1'b0;
    end else if (idx < numIn) begin
      n.data = inBus[idx*W +: W]; n.valid = 1'b1; n.err = 1'b0;
    end else begin
      n.data = '0; n.valid = 1'b1; n.err = 1'b1;
      n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference side: fold the inputs seen at this edge into the model and
  // queue what the registers should hold afterwards.
  always @(posedge clk) begin
    if (!rst_n) begin
      model4 = resetState();
      model3 = resetState();
    end else begin
      model4 = nextState(model4, 4);
      model3 = nextState(model3, 3);
    end
    q4.push_back(model4);
    q3.push_back(model3);
  end

  // Monitor side: outputs are registered, so half a cycle later they must
  // match the queued expectation.
  always @(negedge clk) begin
    expState_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checkOutput("n4 out_data",  outData4,        e.data);
      checkOutput("n4 out_valid", 32'(outValid4),  32'(e.valid));
      checkOutput("n4 sel_err",   32'(selErr4),    32'(e.err));
      checkOutput("n4 err_count", 32'(errCount4),  32'(e.cnt));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      checkOutput("n3 out_data",  outData3,        e.data);
      checkOutput("n3 out_valid", 32'(outValid3),  32'(e.valid));
      checkOutput("n3 sel_err",   32'(selErr3),    32'(e.err));
      checkOutput("n3 err_count", 32'(errCount3),  32'(e.cnt));
    end
  end

  // Inputs change 1 ns after the rising edge and are held for one full cycle.
  task automatic applyStimulus(input logic v, input logic st, input logic fl,
                               input logic [1:0] s);
    inValid = v; stall = st; flush = fl; sel = s;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check that outputs clear immediately,
  // then release it away from the rising edge.
  task automatic midCycleReset();
    @(negedge clk);
    #2;
    inValid = 1'b0; stall = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset n4 out_data",  outData4,        32'h0);
    checkOutput("reset n4 out_valid", 32'(outValid4),  32'h0);
    checkOutput("reset n4 sel_err",   32'(selErr4),    32'h0);
    checkOutput("reset n4 err_count", 32'(errCount4),  32'h0);
    checkOutput("reset n3 out_data",  outData3,        32'h0);
    checkOutput("reset n3 out_valid", 32'(outValid3),  32'h0);
    checkOutput("reset n3 sel_err",   32'(selErr3),    32'h0);
    checkOutput("reset n3 err_count", 32'(errCount3),  32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    inBus   = '0;
    sel     = '0;
    inValid = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Select sweep with the four distinct patterns.
    inBus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b0, 1'b0, 2'(s));

    // Stall for three cycles with a changing select, then stall+flush.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2);
    for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b1, 1'b0, 2'(s));
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1);

    // Bubble after a valid 0xDEADBEEF.
    inBus[W +: W] = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd2);

    // 300 bad selects on the 3-input instance drive its counter into saturation.
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd3);
    // A stalled bad select and a flush must leave the saturated count alone.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset in the middle of a cycle clears the saturated counter.
    midCycleReset();

    // Random regression, with one more mid-cycle reset halfway through.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) midCycleReset();
      inBus = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
